gb_cart_mbc1: RTL and testbench

- Cartridge-side responder for the Game Boy cartridge bus driven by the boy core (a, dout/din, rd, wr).
- Emulates an MBC1 mapper. Decodes bus writes into bank registers.
- Translates CPU reads into banked ROM/RAM addresses on a simple synchronous memory port, and returns read data onto the bus.
- Sits between the cartridge pins and on-board ROM/RAM storage, replacing a physical cartridge.

---
 rtl/gb_cart_pkg.sv | 25 ++
 rtl/gb_bus_sync.sv | 31 +++
 rtl/gb_cart_mbc1.sv | 173 +++++++++++++++++
 tb/tb_gb_cart_mbc1.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/gb_cart_pkg.sv
// Shared definitions for the MBC1 cartridge responder: FSM encoding,
// write-region decode on a[15:13], and the open-bus value.
package gb_cart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_HOLD,
    ST_WR_DONE
  } cart_state_e;

  localparam logic [2:0] REG_RAMEN  = 3'b000;
  localparam logic [2:0] REG_BANKLO = 3'b001;
  localparam logic [2:0] REG_BANKHI = 3'b010;
  localparam logic [2:0] REG_MODE   = 3'b011;
  localparam logic [2:0] RAM_BASE   = 3'b101;

  localparam logic [7:0] OPEN_BUS = 8'hFF;

  // Bank 0 cannot be selected in the switchable window; only the 5-bit field is tested.
  function automatic logic [4:0] bank_lo_fix(input logic [4:0] v);
    return (v == 5'd0) ? 5'd1 : v;
  endfunction

endpackage

// File: rtl/gb_bus_sync.sv
// Synchronizes one asynchronous bus strobe into clk and flags its
// rising and falling edges for one cycle each.
module gb_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_p0;
  logic                   prev_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_p0 <= '0;
      prev_p1  <= 1'b0;
    end else begin
      chain_p0 <= (chain_p0 << 1) | SYNC_STAGES'(strobe);
      prev_p1  <= chain_p0[SYNC_STAGES-1];
    end
  end

  assign level = chain_p0[SYNC_STAGES-1];
  assign rise  = level & ~prev_p1;
  assign fall  = ~level & prev_p1;

endmodule

// File: rtl/gb_cart_mbc1.sv
// MBC1 cartridge emulation: decodes bus writes into bank registers and
// turns bus reads into banked ROM/RAM requests on a fixed-latency memory port.
module gb_cart_mbc1
  import gb_cart_pkg::*;
#(
  parameter int ROM_AW      = 21,
  parameter int RAM_AW      = 15,
  parameter int MEM_LAT     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       bus_a,
  input  logic [7:0]        bus_din,
  input  logic              bus_rd,
  input  logic              bus_wr,
  output logic [7:0]        bus_dout,
  output logic              bus_oe,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              mem_sel_ram,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  logic [1:0]  rst_q;
  logic        rst_n;
  logic        rd_level, rd_rise, rd_fall;
  logic        wr_level, wr_rise, wr_fall;
  cart_state_e state;
  logic [2:0]  cnt;
  logic        rd_dropped;
  logic        ram_en;
  logic [4:0]  bank_lo;
  logic [1:0]  bank_hi;
  logic        mode;

  // Reset asserts immediately and releases two clk edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_q <= 2'b00;
    else      rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_n = rst_q[1];

  gb_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (bus_rd),
    .level  (rd_level),
    .rise   (rd_rise),
    .fall   (rd_fall)
  );

  gb_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (bus_wr),
    .level  (wr_level),
    .rise   (wr_rise),
    .fall   (wr_fall)
  );

  function automatic logic [ROM_AW-1:0] rom_map(input logic upper, input logic [13:0] off,
                                               input logic [1:0] hi, input logic [4:0] lo,
                                               input logic m);
    logic [20:0] full;
    if (upper) full = {hi, lo, off};
    else       full = {(m ? hi : 2'b00), 5'b00000, off};
    return full[ROM_AW-1:0];
  endfunction

  function automatic logic [RAM_AW-1:0] ram_map(input logic [12:0] off, input logic [1:0] hi,
                                               input logic m);
    logic [14:0] full;
    full = {(m ? hi : 2'b00), off};
    return full[RAM_AW-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bus_dout    <= OPEN_BUS;
      bus_oe      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_wdata   <= 8'h00;
      ram_en      <= 1'b0;
      bank_lo     <= 5'd1;
      bank_hi     <= 2'd0;
      mode        <= 1'b0;
      cnt         <= 3'd0;
      rd_dropped  <= 1'b0;
      rom_addr    <= '0;
      ram_addr    <= '0;
      mem_sel_ram <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (wr_rise) begin
            state <= ST_WR_DONE;
            case (bus_a[15:13])
              REG_RAMEN:  ram_en  <= (bus_din[3:0] == 4'hA);
              REG_BANKLO: bank_lo <= bank_lo_fix(bus_din[4:0]);
              REG_BANKHI: bank_hi <= bus_din[1:0];
              REG_MODE:   mode    <= bus_din[0];
              RAM_BASE: begin
                if (ram_en) begin
                  mem_wr      <= 1'b1;
                  mem_wdata   <= bus_din;
                  ram_addr    <= ram_map(bus_a[12:0], bank_hi, mode);
                  mem_sel_ram <= 1'b1;
                end
              end
              default: ;
            endcase
          end else if (rd_rise) begin
            rd_dropped <= 1'b0;
            if (!bus_a[15]) begin
              rom_addr    <= rom_map(bus_a[14], bus_a[13:0], bank_hi, bank_lo, mode);
              mem_sel_ram <= 1'b0;
              mem_rd      <= 1'b1;
              cnt         <= 3'(MEM_LAT);
              state       <= ST_RD_WAIT;
            end else if (bus_a[15:13] == RAM_BASE) begin
              if (ram_en) begin
                ram_addr    <= ram_map(bus_a[12:0], bank_hi, mode);
                mem_sel_ram <= 1'b1;
                mem_rd      <= 1'b1;
                cnt         <= 3'(MEM_LAT);
                state       <= ST_RD_WAIT;
              end else begin
                // Disabled RAM reads back as open bus without touching memory.
                bus_dout <= OPEN_BUS;
                bus_oe   <= 1'b1;
                state    <= ST_RD_HOLD;
              end
            end
          end
        end
        ST_RD_WAIT: begin
          if (rd_fall) rd_dropped <= 1'b1;
          if (cnt == 3'd0) begin
            // A strobe that fell at any point during the wait forfeits the data.
            if (rd_level && !rd_dropped) begin
              bus_dout <= mem_rdata;
              bus_oe   <= 1'b1;
              state    <= ST_RD_HOLD;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_RD_HOLD: begin
          if (!rd_level) begin
            bus_oe <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_WR_DONE: begin
          if (wr_fall || !wr_level) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_cart_mbc1.sv
// Directed bench for gb_cart_mbc1: bank register writes, banked read mapping,
// RAM gating, early strobe release, rd/wr collision and mid-access reset.
module tb_gb_cart_mbc1;

  localparam int ROM_AW      = 21;
  localparam int RAM_AW      = 15;
  localparam int MEM_LAT     = 2;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [15:0]       bus_a = 16'h0000;
  logic [7:0]        bus_din = 8'h00;
  logic              bus_rd = 1'b0;
  logic              bus_wr = 1'b0;
  logic [7:0]        bus_dout;
  logic              bus_oe;
  logic [ROM_AW-1:0] rom_addr;
  logic [RAM_AW-1:0] ram_addr;
  logic              mem_sel_ram;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = 8'h00;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gb_cart_mbc1 #(
    .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .MEM_LAT(MEM_LAT), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .bus_a(bus_a), .bus_din(bus_din), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_dout(bus_dout), .bus_oe(bus_oe), .rom_addr(rom_addr), .ram_addr(ram_addr),
    .mem_sel_ram(mem_sel_ram), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Full read transaction; cycles counted in negedges after bus_rd rises.
  task automatic do_read(input logic [15:0] addr, output int rd_cnt, output int rd_cyc,
                         output int oe_cyc, output logic [7:0] dout, output logic oe_after);
    rd_cnt = 0; rd_cyc = -1; oe_cyc = -1;
    @(negedge clk);
    bus_a = addr; bus_rd = 1'b1;
    for (int i = 1; i <= 20 && oe_cyc < 0; i++) begin
      @(negedge clk);
      if (mem_rd) begin rd_cnt++; if (rd_cyc < 0) rd_cyc = i; end
      if (bus_oe) oe_cyc = i;
    end
    dout = bus_dout;
    @(negedge clk);
    bus_rd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_rd) rd_cnt++;
    end
    oe_after = bus_oe;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input logic also_rd,
                          output int wr_cnt, output int rd_cnt);
    wr_cnt = 0; rd_cnt = 0;
    @(negedge clk);
    bus_a = addr; bus_din = data; bus_wr = 1'b1; bus_rd = also_rd;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_wr) wr_cnt++;
      if (mem_rd) rd_cnt++;
    end
    bus_wr = 1'b0; bus_rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_wr) wr_cnt++;
      if (mem_rd) rd_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus_dout !== 8'hFF) begin bad++; $display("FAIL reset_dout got=%h exp=ff", bus_dout); end
    total++; if (bus_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", bus_oe); end
    total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
    total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
    total++; if (mem_wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h exp=00", mem_wdata); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_rom_read();
    int rc, rcyc, oec; logic [7:0] d; logic oa;
    mem_rdata = 8'hC3;
    do_read(16'h4123, rc, rcyc, oec, d, oa);
    total++; if (rom_addr !== 21'h004123) begin bad++; $display("FAIL rom_read_addr got=%h exp=004123", rom_addr); end
    total++; if (mem_sel_ram !== 1'b0) begin bad++; $display("FAIL rom_read_sel got=%b exp=0", mem_sel_ram); end
    total++; if (rc != 1) begin bad++; $display("FAIL rom_read_rdcount got=%0d exp=1", rc); end
    total++; if (rcyc != 3) begin bad++; $display("FAIL rom_read_rdcycle got=%0d exp=3", rcyc); end
    total++; if (oec - rcyc != 1 + MEM_LAT) begin bad++; $display("FAIL rom_read_latency got=%0d exp=%0d", oec - rcyc, 1 + MEM_LAT); end
    total++; if (d !== 8'hC3) begin bad++; $display("FAIL rom_read_data got=%h exp=c3", d); end
    total++; if (oa !== 1'b0) begin bad++; $display("FAIL rom_read_oe_release got=%b exp=0", oa); end
  endtask

  task automatic test_bank_lo();
    int rc, rcyc, oec, wc, wrc; logic [7:0] d; logic oa;
    do_write(16'h2000, 8'h00, 1'b0, wc, wrc);
    total++; if (wc != 0) begin bad++; $display("FAIL banklo_reg_no_memwr got=%0d exp=0", wc); end
    do_read(16'h4000, rc, rcyc, oec, d, oa);
    total++; if (rom_addr !== 21'h004000) begin bad++; $display("FAIL banklo_zero got=%h exp=004000", rom_addr); end
    do_write(16'h2000, 8'h25, 1'b0, wc, wrc);
    do_read(16'h7FFF, rc, rcyc, oec, d, oa);
    total++; if (rom_addr !== 21'h017FFF) begin bad++; $display("FAIL banklo_25 got=%h exp=017fff", rom_addr); end
    do_write(16'h2000, 8'h20, 1'b0, wc, wrc);
    do_read(16'h4000, rc, rcyc, oec, d, oa);
    total++; if (rom_addr !== 21'h004000) begin bad++; $display("FAIL banklo_20 got=%h exp=004000", rom_addr); end
  endtask

  task automatic test_open_bus();
    int rc, rcyc, oec; logic [7:0] d; logic oa;
    do_read(16'h8000, rc, rcyc, oec, d, oa);
    total++; if (rc != 0) begin bad++; $display("FAIL open_bus_rd got=%0d exp=0", rc); end
    total++; if (oec != -1) begin bad++; $display("FAIL open_bus_oe got=%0d exp=-1", oec); end
  endtask

  task automatic test_same_cycle();
    int rc, rcyc, oec, wc, wrc; logic [7:0] d; logic oa;
    do_write(16'h2000, 8'h03, 1'b1, wc, wrc);
    total++; if (wrc != 0) begin bad++; $display("FAIL collide_no_rd got=%0d exp=0", wrc); end
    do_read(16'h4000, rc, rcyc, oec, d, oa);
    total++; if (rom_addr !== 21'h00C000) begin bad++; $display("FAIL collide_write got=%h exp=00c000", rom_addr); end
  endtask

  task automatic test_rd_drop();
    int rc, rcyc, oec; logic [7:0] d; logic oa; int drc; logic oe_seen;
    drc = 0; oe_seen = 1'b0;
    mem_rdata = 8'h66;
    @(negedge clk);
    bus_a = 16'h4000; bus_rd = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_rd) drc++;
      if (bus_oe) oe_seen = 1'b1;
      if (i == 3) bus_rd = 1'b0;
    end
    total++; if (drc != 1) begin bad++; $display("FAIL drop_rd_issued got=%0d exp=1", drc); end
    total++; if (oe_seen !== 1'b0) begin bad++; $display("FAIL drop_oe got=%b exp=0", oe_seen); end
    mem_rdata = 8'h77;
    do_read(16'h4000, rc, rcyc, oec, d, oa);
    total++; if (rcyc != 3) begin bad++; $display("FAIL drop_idle_rdcycle got=%0d exp=3", rcyc); end
    total++; if (d !== 8'h77) begin bad++; $display("FAIL drop_idle_data got=%h exp=77", d); end
  endtask

  task automatic test_bank_hi_mode();
    int rc, rcyc, oec, wc, wrc; logic [7:0] d; logic oa;
    do_write(16'h4000, 8'h03, 1'b0, wc, wrc);
    do_write(16'h6000, 8'h01, 1'b0, wc, wrc);
    do_read(16'h0010, rc, rcyc, oec, d, oa);
    total++; if (rom_addr !== 21'h180010) begin bad++; $display("FAIL mode1_low got=%h exp=180010", rom_addr); end
    do_read(16'h4000, rc, rcyc, oec, d, oa);
    total++; if (rom_addr !== 21'h18C000) begin bad++; $display("FAIL mode1_high got=%h exp=18c000", rom_addr); end
    do_write(16'h0000, 8'h0A, 1'b0, wc, wrc);
    mem_rdata = 8'h5E;
    do_read(16'hA005, rc, rcyc, oec, d, oa);
    total++; if (ram_addr !== 15'h6005) begin bad++; $display("FAIL ram_read_addr got=%h exp=6005", ram_addr); end
    total++; if (mem_sel_ram !== 1'b1) begin bad++; $display("FAIL ram_read_sel got=%b exp=1", mem_sel_ram); end
    total++; if (d !== 8'h5E) begin bad++; $display("FAIL ram_read_data got=%h exp=5e", d); end
  endtask

  task automatic test_ram_write();
    int rc, rcyc, oec, wc, wrc; logic [7:0] d; logic oa;
    do_write(16'h0000, 8'h00, 1'b0, wc, wrc);
    do_write(16'hA000, 8'h5A, 1'b0, wc, wrc);
    total++; if (wc != 0) begin bad++; $display("FAIL ram_wr_disabled got=%0d exp=0", wc); end
    do_write(16'h0000, 8'h0A, 1'b0, wc, wrc);
    do_write(16'hA000, 8'h5A, 1'b0, wc, wrc);
    total++; if (wc != 1) begin bad++; $display("FAIL ram_wr_count got=%0d exp=1", wc); end
    total++; if (mem_wdata !== 8'h5A) begin bad++; $display("FAIL ram_wr_data got=%h exp=5a", mem_wdata); end
    total++; if (ram_addr !== 15'h6000) begin bad++; $display("FAIL ram_wr_addr got=%h exp=6000", ram_addr); end
    do_write(16'h0000, 8'h00, 1'b0, wc, wrc);
    mem_rdata = 8'h11;
    do_read(16'hB000, rc, rcyc, oec, d, oa);
    total++; if (rc != 0) begin bad++; $display("FAIL ram_rd_disabled_rd got=%0d exp=0", rc); end
    total++; if (d !== 8'hFF) begin bad++; $display("FAIL ram_rd_disabled_data got=%h exp=ff", d); end
  endtask

  task automatic test_reset_mid();
    int rc, rcyc, oec, wc, wrc; logic [7:0] d; logic oa; logic hold;
    hold = 1'b0;
    mem_rdata = 8'h99;
    @(negedge clk);
    bus_a = 16'h4123; bus_rd = 1'b1;
    for (int i = 0; i < 20 && !hold; i++) begin
      @(negedge clk);
      if (bus_oe) hold = 1'b1;
    end
    total++; if (hold !== 1'b1) begin bad++; $display("FAIL midrst_reach_hold got=%b exp=1", hold); end
    rst = 1'b0;
    #1;
    total++; if (bus_oe !== 1'b0) begin bad++; $display("FAIL midrst_oe got=%b exp=0", bus_oe); end
    total++; if (bus_dout !== 8'hFF) begin bad++; $display("FAIL midrst_dout got=%h exp=ff", bus_dout); end
    bus_rd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    mem_rdata = 8'h42;
    do_read(16'h4000, rc, rcyc, oec, d, oa);
    total++; if (rom_addr !== 21'h004000) begin bad++; $display("FAIL midrst_bank got=%h exp=004000", rom_addr); end
    total++; if (d !== 8'h42) begin bad++; $display("FAIL midrst_data got=%h exp=42", d); end
    do_read(16'h0010, rc, rcyc, oec, d, oa);
    total++; if (rom_addr !== 21'h000010) begin bad++; $display("FAIL midrst_mode got=%h exp=000010", rom_addr); end
    do_write(16'hA000, 8'h5A, 1'b0, wc, wrc);
    total++; if (wc != 0) begin bad++; $display("FAIL midrst_ram_en got=%0d exp=0", wc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_rom_read();
    test_bank_lo();
    test_open_bus();
    test_same_cycle();
    test_rd_drop();
    test_bank_hi_mode();
    test_ram_write();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
